// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_pipe
// Description : Decode-stage immediate generator for RV32/RV64. Extracts and
//               extends I/U/S/B/J/Z/SH immediates to XLEN bits and registers
//               them behind a valid/ready handshake with a 2-entry skid
//               buffer. Supports flush and counts illegal ImmSrc encodings.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      instr_imm,
    input  logic [2:0]       ImmSrc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  ImmOp,
    output logic             imm_illegal,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [2:0] c_fmt_i  = 3'b000;
    localparam logic [2:0] c_fmt_u  = 3'b001;
    localparam logic [2:0] c_fmt_s  = 3'b010;
    localparam logic [2:0] c_fmt_b  = 3'b011;
    localparam logic [2:0] c_fmt_j  = 3'b100;
    localparam logic [2:0] c_fmt_z  = 3'b101;
    localparam logic [2:0] c_fmt_sh = 3'b110;

    // Instruction bits kept at their architectural positions [31:7]
    logic [31:7]     w_instr;
    logic [31:0]     w_imm32;
    logic            w_ill;
    logic [XLEN-1:0] w_imm_ext;
    logic            w_accept;
    logic            w_out_free;

    logic            r_out_valid;
    logic [XLEN-1:0] r_out_imm;
    logic            r_out_ill;
    logic            r_skid_valid;
    logic [XLEN-1:0] r_skid_imm;
    logic            r_skid_ill;
    logic [CNT_W-1:0] r_err_count;

    assign w_instr = instr_imm;

    // Format decode into a 32-bit value whose bit 31 is the correct fill bit
    // for widening (zero for the Z/SH forms and for illegal encodings).
    always_comb begin
        w_imm32 = 32'b0;
        w_ill   = 1'b0;
        case (ImmSrc)
            c_fmt_i:  w_imm32 = {{20{w_instr[31]}}, w_instr[31:20]};
            c_fmt_u:  w_imm32 = {w_instr[31:12], 12'b0};
            c_fmt_s:  w_imm32 = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
            c_fmt_b:  w_imm32 = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                                 w_instr[30:25], w_instr[11:8], 1'b0};
            c_fmt_j:  w_imm32 = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                                 w_instr[20], w_instr[30:21], 1'b0};
            c_fmt_z:  w_imm32 = {27'b0, w_instr[19:15]};
            c_fmt_sh: w_imm32 = {26'b0, (XLEN == 64) ? w_instr[25:20]
                                                     : {1'b0, w_instr[24:20]}};
            default: begin
                w_imm32 = 32'b0;
                w_ill   = 1'b1;
            end
        endcase
    end

    // Widen to XLEN by replicating bit 31
    generate
        if (XLEN == 64) begin : g_xlen64
            assign w_imm_ext = {{32{w_imm32[31]}}, w_imm32};
        end else begin : g_xlen32
            assign w_imm_ext = w_imm32;
        end
    endgenerate

    assign in_ready   = ~r_skid_valid;
    assign w_accept   = in_valid & ~r_skid_valid & ~flush;
    assign w_out_free = ~r_out_valid | out_ready;

    // OUT/SKID pipeline: skid drains first to preserve order; the skid only
    // fills when OUT is stalled, so in_ready never depends on out_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_imm    <= '0;
            r_out_ill    <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_imm   <= '0;
            r_skid_ill   <= 1'b0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                r_out_valid  <= 1'b1;
                r_out_imm    <= r_skid_imm;
                r_out_ill    <= r_skid_ill;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_imm   <= w_imm_ext;
                r_out_ill   <= w_ill;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
            r_skid_imm   <= w_imm_ext;
            r_skid_ill   <= w_ill;
        end
    end

    // Saturating count of accepted illegal encodings; only rst clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (w_accept && w_ill && (r_err_count != {CNT_W{1'b1}})) begin
            r_err_count <= r_err_count + CNT_W'(1);
        end
    end

    assign out_valid   = r_out_valid;
    assign ImmOp       = r_out_imm;
    assign imm_illegal = r_out_ill;
    assign err_count   = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_gen_pipe
// Description : Self-checking bench for imm_gen_pipe. Two instances (XLEN=32
//               with CNT_W=2, XLEN=64 with CNT_W=8) share one input stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [24:0] instr_imm;
    logic [2:0]  imm_src;

    logic        in_ready32, out_valid32, ill32;
    logic [31:0] imm32;
    logic [1:0]  err32;
    logic        in_ready64, out_valid64, ill64;
    logic [63:0] imm64;
    logic [7:0]  err64;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .CNT_W(2)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready32), .instr_imm(instr_imm), .ImmSrc(imm_src),
        .out_valid(out_valid32), .out_ready(out_ready), .ImmOp(imm32),
        .imm_illegal(ill32), .err_count(err32)
    );

    imm_gen_pipe #(.XLEN(64), .CNT_W(8)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready64), .instr_imm(instr_imm), .ImmSrc(imm_src),
        .out_valid(out_valid64), .out_ready(out_ready), .ImmOp(imm64),
        .imm_illegal(ill64), .err_count(err64)
    );

    typedef struct {
        logic [2:0]  src;
        logic [31:0] instr;
        logic [31:0] e32;
        logic [63:0] e64;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [2:0] src, input logic [31:0] instr);
        in_valid  = 1'b1;
        imm_src   = src;
        instr_imm = instr[31:7];
    endtask

    initial begin
        logic [31:0] tmp;
        vecs[0]  = '{3'd0, 32'hFFF0_0000, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[1]  = '{3'd2, 32'h0000_0F80, 32'h0000_001F, 64'h0000_0000_0000_001F};
        vecs[2]  = '{3'd3, 32'hFE00_0C80, 32'hFFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8};
        vecs[3]  = '{3'd5, 32'h000F_8000, 32'h0000_001F, 64'h0000_0000_0000_001F};
        vecs[4]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 64'hFFFF_FFFF_8000_0000};
        vecs[5]  = '{3'd6, 32'h03F0_0000, 32'h0000_001F, 64'h0000_0000_0000_003F};
        vecs[6]  = '{3'd4, 32'hFFFF_FF80, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[7]  = '{3'd0, 32'h7FF0_0000, 32'h0000_07FF, 64'h0000_0000_0000_07FF};
        vecs[8]  = '{3'd1, 32'h1234_5000, 32'h1234_5000, 64'h0000_0000_1234_5000};
        vecs[9]  = '{3'd2, 32'h8000_0000, 32'hFFFF_F800, 64'hFFFF_FFFF_FFFF_F800};
        vecs[10] = '{3'd4, 32'h0020_0000, 32'h0000_0002, 64'h0000_0000_0000_0002};
        vecs[11] = '{3'd5, 32'hFFFF_7FFF, 32'h0000_001E, 64'h0000_0000_0000_001E};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        imm_src = 3'd0; instr_imm = '0;
        step(); step();
        rst = 1'b0;

        // Reset state
        check("rst_out_valid", {63'b0, out_valid32}, 64'd0);
        check("rst_immop32", {32'b0, imm32}, 64'd0);
        check("rst_immop64", imm64, 64'd0);
        check("rst_illegal", {63'b0, ill32}, 64'd0);
        check("rst_err", {62'b0, err32}, 64'd0);
        check("rst_in_ready", {63'b0, in_ready32}, 64'd1);

        // Format table, one entry per cycle, result one cycle after accept
        for (int i = 0; i < 12; i++) begin
            tmp = vecs[i].instr;
            offer(vecs[i].src, tmp);
            step();
            check($sformatf("vec%0d_valid", i), {62'b0, out_valid32, out_valid64}, 64'd3);
            check($sformatf("vec%0d_imm32", i), {32'b0, imm32}, {32'b0, vecs[i].e32});
            check($sformatf("vec%0d_imm64", i), imm64, vecs[i].e64);
            check($sformatf("vec%0d_ill", i), {62'b0, ill32, ill64}, 64'd0);
        end
        in_valid = 1'b0;
        step();
        check("drain_out_valid", {63'b0, out_valid32}, 64'd0);

        // Backpressure: A, B absorbed, C held off, then A, B, C in order
        out_ready = 1'b0;
        offer(3'd0, 32'h0010_0000);             // A = 1
        step();
        check("bp_a_out", {32'b0, imm32}, 64'd1);
        check("bp_a_in_ready", {63'b0, in_ready32}, 64'd1);
        offer(3'd0, 32'h0020_0000);             // B = 2
        step();
        check("bp_b_in_ready", {62'b0, in_ready32, in_ready64}, 64'd0);
        offer(3'd0, 32'h7770_0000);             // D, must be ignored
        step();
        check("bp_hold_in_ready", {63'b0, in_ready32}, 64'd0);
        check("bp_hold_out", {32'b0, imm32}, 64'd1);
        offer(3'd0, 32'h0030_0000);             // C = 3
        out_ready = 1'b1;
        step();
        check("bp_seq_b", {32'b0, imm32}, 64'd2);
        check("bp_seq_b_valid", {63'b0, out_valid32}, 64'd1);
        check("bp_ready_back", {63'b0, in_ready32}, 64'd1);
        step();
        in_valid = 1'b0;
        check("bp_seq_c", {32'b0, imm32}, 64'd3);
        check("bp_seq_c_valid", {63'b0, out_valid32}, 64'd1);
        step();
        check("bp_seq_end", {63'b0, out_valid32}, 64'd0);

        // Flush with both entries full and a new input offered
        out_ready = 1'b0;
        offer(3'd0, 32'h0050_0000);
        step();
        offer(3'd0, 32'h0060_0000);
        step();
        check("fl_full", {63'b0, in_ready32}, 64'd0);
        offer(3'd0, 32'h0070_0000);
        flush = 1'b1;
        out_ready = 1'b1;
        step();
        flush = 1'b0;
        check("fl_out_valid", {62'b0, out_valid32, out_valid64}, 64'd0);
        check("fl_in_ready", {63'b0, in_ready32}, 64'd1);
        in_valid = 1'b0;
        step();
        check("fl_no_leak", {63'b0, out_valid32}, 64'd0);

        // Flush with OUT full, skid empty, and an acceptable input offered
        offer(3'd0, 32'h0080_0000);
        step();
        offer(3'd0, 32'h0090_0000);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl2_out_valid", {63'b0, out_valid32}, 64'd0);
        step();
        check("fl2_no_leak", {63'b0, out_valid32}, 64'd0);
        offer(3'd0, 32'h00A0_0000);
        step();
        in_valid = 1'b0;
        check("fl2_resume", {32'b0, imm32}, 64'h0A);

        // Illegal encodings: five accepts, counter saturates at 3 for CNT_W=2
        for (int i = 0; i < 5; i++) begin
            offer(3'd7, 32'hFFFF_FF80);
            step();
            check($sformatf("ill%0d_imm32", i), {32'b0, imm32}, 64'd0);
            check($sformatf("ill%0d_imm64", i), imm64, 64'd0);
            check($sformatf("ill%0d_flag", i), {62'b0, ill32, ill64}, 64'd3);
        end
        in_valid = 1'b0;
        step();
        check("ill_err32", {62'b0, err32}, 64'd3);
        check("ill_err64", {56'b0, err64}, 64'd5);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("ill_err_after_flush", {62'b0, err32}, 64'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("ill_err_after_rst", {62'b0, err32}, 64'd0);

        // Reset mid-stream with both entries held
        out_ready = 1'b0;
        offer(3'd0, 32'h1230_0000);
        step();
        offer(3'd0, 32'h4560_0000);
        step();
        check("mr_pre_valid", {63'b0, out_valid32}, 64'd1);
        check("mr_pre_skid", {63'b0, in_ready32}, 64'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        check("mr_out_valid", {63'b0, out_valid32}, 64'd0);
        check("mr_immop", imm64, 64'd0);
        check("mr_in_ready", {63'b0, in_ready32}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
